// File: rtl/branch_hazard_if.sv
// Pipeline-side bundle for the branch hazard controller: ID/EX/MEM hazard inputs,
// front-end control outputs and statistics counters.
interface branch_hazard_if #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
);
    logic [1:0]       id_branch;
    logic             id_cmp_zero;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [REG_W-1:0] mem_rd;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pc_src;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_branch, id_cmp_zero, id_rs, id_rt,
        output ex_reg_write, ex_mem_read, ex_rd,
        output mem_reg_write, mem_mem_read, mem_rd,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_src,
        input  branch_cnt, taken_cnt, stall_cnt
    );

    modport slave (
        input  id_branch, id_cmp_zero, id_rs, id_rt,
        input  ex_reg_write, ex_mem_read, ex_rd,
        input  mem_reg_write, mem_mem_read, mem_rd,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pc_src,
        output branch_cnt, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_hazard_controller.sv
// ID-stage branch resolution sequencer: stalls on EX/MEM RAW dependences,
// then redirects the PC and flushes IF/ID on a taken branch.
module branch_hazard_controller #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_hazard_if.slave  bus
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    state_t           state, state_next;
    logic [1:0]       stall_left, stall_left_next;
    logic [1:0]       need;
    logic             ex_match, mem_load_match;
    logic             stall, resolve, taken;
    logic [CNT_W-1:0] branch_q, taken_q, stall_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A load's result reaches the ID comparator two cycles after EX, an ALU result one.
    always_comb begin
        ex_match = bus.ex_reg_write && (bus.ex_rd != ZERO_REG) &&
                   ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));
        mem_load_match = bus.mem_reg_write && bus.mem_mem_read && (bus.mem_rd != ZERO_REG) &&
                         ((bus.mem_rd == bus.id_rs) || (bus.mem_rd == bus.id_rt));
        if (ex_match && bus.ex_mem_read)   need = 2'd2;
        else if (ex_match || mem_load_match) need = 2'd1;
        else                               need = 2'd0;
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_next      = state;
        stall_left_next = stall_left;
        stall           = 1'b0;
        resolve         = 1'b0;
        taken           = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.id_branch != 2'b00) begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need > 2'd1) begin
                            state_next      = STALL;
                            stall_left_next = need - 2'd1;
                        end
                    end else begin
                        resolve = 1'b1;
                        taken   = bus.id_cmp_zero;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (stall_left == 2'd1) begin
                    state_next      = RUN;
                    stall_left_next = 2'd0;
                end else begin
                    stall_left_next = stall_left - 2'd1;
                end
            end
            default: ;
        endcase

        bus.pc_write    = !stall;
        bus.ifid_write  = !stall;
        bus.idex_bubble = stall;
        bus.pc_src      = taken;
        bus.ifid_flush  = taken;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            stall_left <= 2'd0;
            branch_q   <= '0;
            taken_q    <= '0;
            stall_q    <= '0;
        end else begin
            state      <= state_next;
            stall_left <= stall_left_next;
            if (resolve) branch_q <= sat_inc(branch_q);
            if (taken)   taken_q  <= sat_inc(taken_q);
            if (stall)   stall_q  <= sat_inc(stall_q);
        end
    end

    assign bus.branch_cnt = branch_q;
    assign bus.taken_cnt  = taken_q;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed-vector bench for branch_hazard_controller: hazard stalls, resolve,
// reset mid-stall, and counter saturation on a narrow-counter instance.
module tb_branch_hazard_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    branch_hazard_if #(.CNT_W(16), .REG_W(5)) bus ();
    branch_hazard_if #(.CNT_W(4),  .REG_W(5)) sbus ();

    branch_hazard_controller #(.CNT_W(16), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    branch_hazard_controller #(.CNT_W(4),  .REG_W(5)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_branch = 2'b00; bus.id_cmp_zero = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
        bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
        bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_rd = '0;
    endtask

    // Expected outputs packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src}
    task automatic check_outs(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {27'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.pc_src},
              {27'd0, exp});
    endtask

    task automatic check_cnts(input string tag, input int b, input int t, input int s);
        check({tag, "_branch"}, 32'(bus.branch_cnt), 32'(b));
        check({tag, "_taken"},  32'(bus.taken_cnt),  32'(t));
        check({tag, "_stall"},  32'(bus.stall_cnt),  32'(s));
    endtask

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_TAKEN = 5'b11101;

    initial begin
        idle();
        sbus.id_branch = 2'b00; sbus.id_cmp_zero = 1'b0; sbus.id_rs = '0; sbus.id_rt = '0;
        sbus.ex_reg_write = 1'b0; sbus.ex_mem_read = 1'b0; sbus.ex_rd = '0;
        sbus.mem_reg_write = 1'b0; sbus.mem_mem_read = 1'b0; sbus.mem_rd = '0;

        #12;
        check_outs("reset_outs", O_RUN);
        check_cnts("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // No hazard, taken branch resolves in the same cycle
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
        check_outs("nohaz_resolve", O_TAKEN);
        tick(); idle();
        check_cnts("nohaz", 1, 1, 0);

        // ALU producer in EX: one stall, then resolve taken
        bus.id_branch = 2'b10; bus.id_cmp_zero = 1'b1; bus.id_rs = 5'd8;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd8;
        check_outs("alu_stall", O_STALL);
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_rd = '0;
        check_outs("alu_resolve", O_TAKEN);
        tick(); idle();
        check_cnts("alu", 2, 2, 1);

        // Load in EX matching rt: two stalls, then resolve not taken
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b0; bus.id_rt = 5'd9;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9;
        check_outs("load_stall1", O_STALL);
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
        bus.mem_reg_write = 1'b1; bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd9;
        check_outs("load_stall2", O_STALL);
        tick();
        bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_rd = '0;
        check_outs("load_resolve", O_RUN);
        tick(); idle();
        check_cnts("load", 3, 2, 3);

        // Register 0 never stalls
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b1; bus.id_rs = 5'd0;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0;
        check_outs("r0_resolve", O_TAKEN);
        tick(); idle();
        check_cnts("r0", 4, 3, 3);

        // MEM non-load match is forwarded: no stall
        bus.id_branch = 2'b11; bus.id_cmp_zero = 1'b0; bus.id_rs = 5'd12;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd12;
        check_outs("memalu_resolve", O_RUN);
        tick(); idle();
        check_cnts("memalu", 5, 3, 3);

        // MEM load match: one stall, then resolve taken
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b1; bus.id_rs = 5'd14;
        bus.mem_reg_write = 1'b1; bus.mem_mem_read = 1'b1; bus.mem_rd = 5'd14;
        check_outs("memload_stall", O_STALL);
        tick();
        bus.mem_reg_write = 1'b0; bus.mem_mem_read = 1'b0; bus.mem_rd = '0;
        check_outs("memload_resolve", O_TAKEN);
        tick(); idle();
        check_cnts("memload", 6, 4, 4);

        // Non-branch instruction with an EX match: no stall
        bus.id_rs = 5'd8; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd8;
        check_outs("nonbranch", O_RUN);
        tick(); idle();
        check_cnts("nonbranch", 6, 4, 4);

        // ex_mem_read without ex_reg_write is not a producer
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b0; bus.id_rs = 5'd7;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7;
        check_outs("noregwrite", O_RUN);
        tick(); idle();

        // Reset asserted during the first cycle of a load stall
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b1; bus.id_rt = 5'd9;
        bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9;
        check_outs("rst_pre_stall", O_STALL);
        rst_n = 1'b0;
        idle();
        check_outs("rst_mid_outs", O_RUN);
        check_cnts("rst_mid", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.id_branch = 2'b01; bus.id_cmp_zero = 1'b0; bus.id_rs = 5'd9;
        check_outs("post_rst_resolve", O_RUN);
        tick(); idle();
        check_cnts("post_rst", 1, 0, 0);

        // Saturation on the 4-bit counter instance
        sbus.id_branch = 2'b01; sbus.id_cmp_zero = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        sbus.id_branch = 2'b00;
        #1;
        check("sat_branch", 32'(sbus.branch_cnt), 32'd15);
        check("sat_taken",  32'(sbus.taken_cnt),  32'd15);
        check("sat_stall",  32'(sbus.stall_cnt),  32'd0);
        tick();
        check("sat_hold", 32'(sbus.branch_cnt), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
Sequences ID-stage branch resolution in the five-stage MIPS pipeline. Detects RAW dependences between an ID-stage branch's source registers and producers in EX/MEM, holds the front end for the required cycles, then asserts PC redirect and IF/ID flush on a taken branch. Also keeps saturating branch/stall statistics counters. Sits beside the hazard unit, driving PC write enable, IF/ID write/flush and the ID/EX bubble.

Parameters:
CNT_W, 16, width of each statistics counter (saturating)
REG_W, 5, register-specifier width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_branch  in  2  branch control of ID instruction; any nonzero value = conditional branch
id_cmp_zero  in  1  ID comparator result; branch taken when 1 (comparator encodes beq/bne sense)
id_rs  in  REG_W  ID source register rs
id_rt  in  REG_W  ID source register rt
ex_reg_write  in  1  EX instruction writes a register
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination register
mem_reg_write  in  1  MEM instruction writes a register
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  REG_W  MEM destination register
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register write enable
ifid_flush  out  1  zero IF/ID on next edge
idex_bubble  out  1  insert NOP into ID/EX
pc_src  out  1  select branch target for PC
branch_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches taken
stall_cnt  out  CNT_W  stall cycles inserted

Behaviour:
- Dependence match: producer valid, rd != 0, rd == id_rs or rd == id_rt.
- Required stalls (evaluated only in RUN, only when id_branch != 0): EX load match -> 2; EX non-load match -> 1; MEM load match -> 1; multiple matches -> maximum. MEM non-load match -> 0 (forwarded to comparator elsewhere).
- States: RUN, STALL. Registered 2-bit stall_left.
- RUN, branch with need N>0: stall this cycle; go STALL with stall_left = N-1 if N-1>0, else remain RUN (the single stall cycle re-evaluates next cycle, where the producer has moved on).
- STALL: stall every cycle; decrement stall_left; at stall_left==1 -> RUN with stall_left=0. No re-detection while in STALL.
- Stall cycle outputs: pc_write=0, ifid_write=0, idex_bubble=1, pc_src=0, ifid_flush=0; stall_cnt += 1.
- Resolve cycle (RUN, id_branch != 0, need==0): pc_write=1, ifid_write=1, idex_bubble=0; if id_cmp_zero=1 -> pc_src=1, ifid_flush=1, taken_cnt += 1; branch_cnt += 1 either way.
- Non-branch cycle in RUN: pc_write=1, ifid_write=1, others 0.
- Outputs combinational from state + inputs; counters and state registered.
- Counters saturate at all-ones; no wrap.
- Reset (async, any time incl. mid-stall): state=RUN, stall_left=0, counters=0; outputs then pc_write=1, ifid_write=1, idex_bubble=0, pc_src=0, ifid_flush=0 (given id_branch=0).
- Register 0 never causes a stall; ex_mem_read ignored unless ex_reg_write=1.

Test Plan:
- No hazard: id_branch=01, id_cmp_zero=1, producers idle -> same cycle pc_src=1, ifid_flush=1; branch_cnt=1, taken_cnt=1, stall_cnt=0.
- ALU in EX: ex_reg_write=1, ex_rd=8, id_rs=8, branch -> 1 stall cycle (pc_write=0, idex_bubble=1); next cycle (EX/MEM cleared) resolves; stall_cnt=1.
- Load in EX: ex_mem_read=1, ex_rd=9=id_rt -> exactly 2 stall cycles, then resolve with id_cmp_zero=0 -> pc_src=0, ifid_flush=0; stall_cnt=2, taken_cnt=0.
- rd=0 match: ex_reg_write=1, ex_rd=0, id_rs=0 -> no stall, immediate resolve.
- Reset mid-stall: assert rst_n=0 during load stall's first cycle -> outputs/counters at reset values immediately, no residual stall after release.
- Saturation: CNT_W=4 build, 20 taken branches -> branch_cnt=taken_cnt=15 held.
